adder_share_arb: RTL and testbench



---
 rtl/adder_share_arb_if.sv | 28 ++
 rtl/adder_share_arb.sv | 152 +++++++++++++++
 tb/tb_adder_share_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arb_if.sv
// Request/response bundle for the shared-adder arbiter: NREQ operand offer
// channels and one result channel, each a valid/ready handshake.
interface adder_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one ripple-carry adder among NREQ requesters;
// one operation in flight, sequenced IDLE -> GRANT -> COMPUTE -> RESP.
module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  adder_share_arb_if.slave bus,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, GRANT, COMPUTE, RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  grant_id_q;
  logic [IDW-1:0]  op_id_q;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic            op_cin_q;
  logic            rsp_valid_q;
  logic [W-1:0]    rsp_sum_q;
  logic            rsp_cout_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [CNTW-1:0] cnt_q;
  logic            busy_q;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [IDW:0]    cand_w;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_cin;
  logic [IDW-1:0]  ptr_d;
  logic [W:0]      add_res;

  function automatic logic [W:0] ripple_add(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic         cin);
    logic         c;
    logic [W-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  // Rotating priority search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_w    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_w = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_w >= (IDW+1)'(NREQ)) cand_w = cand_w - (IDW+1)'(NREQ);
      if (!win_found && bus.req_valid[cand_w[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand_w[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id_q == IDW'(k)) begin
        sel_a   = bus.req_a[k*W +: W];
        sel_b   = bus.req_b[k*W +: W];
        sel_cin = bus.req_cin[k];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == GRANT && !rst) bus.req_ready[grant_id_q] = 1'b1;
  end

  assign ptr_d   = (op_id_q == IDW'(NREQ-1)) ? '0 : op_id_q + 1'b1;
  assign add_res = ripple_add(op_a_q, op_b_q, op_cin_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      op_id_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_id_q <= win_id;
            state_q    <= GRANT;
            busy_q     <= 1'b1;
          end
        end
        // Operands are taken even if valid dropped; requesters must hold them.
        GRANT: begin
          op_a_q   <= sel_a;
          op_b_q   <= sel_b;
          op_cin_q <= sel_cin;
          op_id_q  <= grant_id_q;
          state_q  <= COMPUTE;
        end
        COMPUTE: begin
          rsp_sum_q   <= add_res[W-1:0];
          rsp_cout_q  <= add_res[W];
          rsp_id_q    <= op_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = busy_q;
  assign op_count      = cnt_q;
endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: scenario tasks against a queue-free reference
// (rotating-priority pick and plain-integer addition).
module tb_adder_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            busy;
  logic [CNTW-1:0] op_count;

  int              errors = 0;
  int              checks = 0;
  int              model_ptr = 0;
  logic [CNTW-1:0] model_count = '0;

  adder_share_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  adder_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      for (int j = 0; j < NREQ; j++) if (j == idx && v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return (W+1)'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    for (int j = 0; j < NREQ; j++) if (j == i) v[j] = 1'b1;
    return v;
  endfunction

  task automatic set_op(input int rid, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
    for (int j = 0; j < NREQ; j++) begin
      if (j == rid) begin
        bus.req_a[j*W +: W] = a;
        bus.req_b[j*W +: W] = b;
        bus.req_cin[j]      = c;
      end
    end
  endtask

  task automatic get_op(input int rid, output logic [W-1:0] a, output logic [W-1:0] b,
                        output logic c);
    a = '0; b = '0; c = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (j == rid) begin
        a = bus.req_a[j*W +: W];
        b = bus.req_b[j*W +: W];
        c = bus.req_cin[j];
      end
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_ptr   = 0;
    model_count = '0;
  endtask

  task automatic wait_ready(output logic [NREQ-1:0] vec);
    vec = '0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus.req_ready != '0) begin
        vec = bus.req_ready;
        return;
      end
    end
  endtask

  task automatic wait_rsp(output logic [W-1:0] s, output logic c, output logic [IDW-1:0] id);
    s = 'x; c = 1'bx; id = 'x;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) begin
        s = bus.rsp_sum; c = bus.rsp_cout; id = bus.rsp_id;
        return;
      end
    end
  endtask

  task automatic test_reset;
    logic [NREQ-1:0] vec;
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_cout !== 1'b0 || bus.rsp_id !== '0) begin
      errors++; $display("FAIL reset_rsp: got v=%b s=%h c=%b id=%0d want all 0", bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id); end
    checks++; if (op_count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_cnt_busy: got cnt=%0d busy=%b want 0/0", op_count, busy); end
    rst = 1'b0;
    model_ptr = 0; model_count = '0;
    wait_ready(vec);
    checks++; if (vec !== onehot(pick('1, model_ptr))) begin errors++; $display("FAIL reset_first_grant: got %b want %b", vec, onehot(pick('1, model_ptr))); end
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_forces_ready: got %b want 0", bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = '0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_in_grant: got busy=%b v=%b want 0/0", busy, bus.rsp_valid); end
    model_ptr = 0; model_count = '0;
  endtask

  task automatic test_single;
    logic [NREQ-1:0] v, rvec;
    logic [W:0]      exp_r;
    logic [W-1:0]    s;
    logic            c;
    logic [IDW-1:0]  id;
    int rc, np, vc, eg;
    v = onehot(1);
    set_op(1, 8'h3C, 8'h05, 1'b0);
    exp_r = ref_add(8'h3C, 8'h05, 1'b0);
    eg = pick(v, model_ptr);
    bus.rsp_ready = 1'b1;
    bus.req_valid = v;
    rc = -1; np = 0; vc = -1; rvec = '0; s = 'x; c = 1'bx; id = 'x;
    for (int n = 1; n <= 8 && vc < 0; n++) begin
      @(posedge clk); #1;
      if (rc > 0 && n == rc + 1) bus.req_valid = '0;
      if (bus.req_ready != '0) begin
        np++;
        if (rc < 0) begin rc = n; rvec = bus.req_ready; end
      end
      if (bus.rsp_valid === 1'b1) begin vc = n; s = bus.rsp_sum; c = bus.rsp_cout; id = bus.rsp_id; end
    end
    bus.req_valid = '0;
    checks++; if (rvec !== onehot(eg) || np != 1) begin errors++; $display("FAIL single_ready: got %b x%0d want %b x1", rvec, np, onehot(eg)); end
    checks++; if (rc != 1 || vc != 3) begin errors++; $display("FAIL single_latency: got ready@%0d rsp@%0d want 1/3", rc, vc); end
    checks++; if (s !== exp_r[W-1:0] || c !== exp_r[W] || id !== IDW'(eg)) begin
      errors++; $display("FAIL single_rsp: got s=%h c=%b id=%0d want s=%h c=%b id=%0d", s, c, id, exp_r[W-1:0], exp_r[W], eg); end
    @(posedge clk); #1;
    model_ptr = (eg + 1) % NREQ; model_count = model_count + 1'b1;
    checks++; if (op_count !== model_count || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_accept: got cnt=%0d v=%b want %0d/0", op_count, bus.rsp_valid, model_count); end
    checks++; if (bus.rsp_sum !== exp_r[W-1:0] || bus.rsp_id !== IDW'(eg)) begin errors++; $display("FAIL single_retain: got s=%h id=%0d want %h/%0d", bus.rsp_sum, bus.rsp_id, exp_r[W-1:0], eg); end
  endtask

  task automatic test_carry;
    logic [W-1:0] av [2] = '{8'hFF, 8'h80};
    logic [W-1:0] bv [2] = '{8'h01, 8'h80};
    logic         cv [2] = '{1'b1, 1'b0};
    logic [NREQ-1:0] vec;
    logic [W:0]      exp_r;
    logic [W-1:0]    s;
    logic            c;
    logic [IDW-1:0]  id;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      set_op(0, av[t], bv[t], cv[t]);
      exp_r = ref_add(av[t], bv[t], cv[t]);
      bus.req_valid = onehot(0);
      wait_ready(vec);
      wait_rsp(s, c, id);
      bus.req_valid = '0;
      checks++; if (s !== exp_r[W-1:0] || c !== exp_r[W] || id !== '0) begin
        errors++; $display("FAIL carry_%0d: got s=%h c=%b id=%0d want s=%h c=%b id=0", t, s, c, id, exp_r[W-1:0], exp_r[W]); end
      @(posedge clk); #1;
      model_ptr = 1; model_count = model_count + 1'b1;
    end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] vec, seen;
    logic [W:0]      exp_r;
    logic [W-1:0]    s, a, b;
    logic            c, ci;
    logic [IDW-1:0]  id;
    int eg;
    do_reset();
    for (int r = 0; r < NREQ; r++) set_op(r, W'($urandom), W'($urandom), 1'($urandom));
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    seen = '0;
    for (int g = 0; g < 6; g++) begin
      eg = pick('1, model_ptr);
      wait_ready(vec);
      checks++; if (vec !== onehot(eg)) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", g, vec, onehot(eg)); end
      if (g < NREQ) seen = seen | vec;
      get_op(eg, a, b, ci);
      exp_r = ref_add(a, b, ci);
      wait_rsp(s, c, id);
      if (g == 5) bus.req_valid = '0;
      checks++; if (s !== exp_r[W-1:0] || c !== exp_r[W] || id !== IDW'(eg)) begin
        errors++; $display("FAIL rr_rsp_%0d: got s=%h c=%b id=%0d want s=%h c=%b id=%0d", g, s, c, id, exp_r[W-1:0], exp_r[W], eg); end
      set_op(eg, W'($urandom), W'($urandom), 1'($urandom));
      model_ptr = (eg + 1) % NREQ; model_count = model_count + 1'b1;
    end
    checks++; if (seen !== '1) begin errors++; $display("FAIL rr_fairness: got %b want all granted", seen); end
    @(posedge clk); #1;
    checks++; if (op_count !== model_count) begin errors++; $display("FAIL rr_count: got %0d want %0d", op_count, model_count); end
  endtask

  task automatic test_backpressure;
    logic [NREQ-1:0] vec, others;
    logic [W:0]      exp_r;
    logic [W-1:0]    s, a, b;
    logic            c, ci;
    logic [IDW-1:0]  id;
    int rid, eg;
    rid = $urandom_range(0, NREQ-1);
    for (int r = 0; r < NREQ; r++) set_op(r, W'($urandom), W'($urandom), 1'($urandom));
    others = ~onehot(rid);
    bus.rsp_ready = 1'b0;
    bus.req_valid = onehot(rid);
    eg = pick(onehot(rid), model_ptr);
    get_op(eg, a, b, ci);
    exp_r = ref_add(a, b, ci);
    wait_ready(vec);
    checks++; if (vec !== onehot(eg)) begin errors++; $display("FAIL bp_grant: got %b want %b", vec, onehot(eg)); end
    @(posedge clk); #1;
    bus.req_valid = others;
    wait_rsp(s, c, id);
    checks++; if (s !== exp_r[W-1:0] || c !== exp_r[W] || id !== IDW'(eg)) begin
      errors++; $display("FAIL bp_rsp: got s=%h c=%b id=%0d want s=%h c=%b id=%0d", s, c, id, exp_r[W-1:0], exp_r[W], eg); end
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== exp_r[W-1:0] || bus.rsp_id !== IDW'(eg)) begin
        errors++; $display("FAIL bp_hold_%0d: got v=%b s=%h id=%0d want 1/%h/%0d", n, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, exp_r[W-1:0], eg); end
      checks++; if (bus.req_ready !== '0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_idle_req_%0d: got ready=%b busy=%b want 0/1", n, bus.req_ready, busy); end
    end
    bus.rsp_ready = 1'b1;
    model_ptr = (eg + 1) % NREQ; model_count = model_count + 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0 || op_count !== model_count || bus.req_ready !== '0) begin
      errors++; $display("FAIL bp_accept: got v=%b cnt=%0d ready=%b want 0/%0d/0", bus.rsp_valid, op_count, bus.req_ready, model_count); end
    eg = pick(others, model_ptr);
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== onehot(eg)) begin errors++; $display("FAIL bp_next_grant: got %b want %b", bus.req_ready, onehot(eg)); end
    get_op(eg, a, b, ci);
    exp_r = ref_add(a, b, ci);
    wait_rsp(s, c, id);
    bus.req_valid = '0;
    checks++; if (s !== exp_r[W-1:0] || c !== exp_r[W] || id !== IDW'(eg)) begin
      errors++; $display("FAIL bp_rsp2: got s=%h c=%b id=%0d want s=%h c=%b id=%0d", s, c, id, exp_r[W-1:0], exp_r[W], eg); end
    model_ptr = (eg + 1) % NREQ; model_count = model_count + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] vec, v;
    logic [W:0]      exp_r;
    logic [W-1:0]    s, a, b;
    logic            c, ci;
    logic [IDW-1:0]  id;
    int eg;
    bus.rsp_ready = 1'b1;
    set_op(3, W'($urandom), W'($urandom), 1'($urandom));
    bus.req_valid = onehot(3);
    wait_ready(vec);
    checks++; if (vec !== onehot(3)) begin errors++; $display("FAIL rm_grant: got %b want %b", vec, onehot(3)); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = '0;
    model_ptr = 0; model_count = '0;
    for (int n = 0; n < 4; n++) begin
      checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_no_rsp_%0d: got v=%b busy=%b want 0/0", n, bus.rsp_valid, busy); end
      @(posedge clk); #1;
    end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL rm_count: got %0d want 0", op_count); end
    set_op(0, W'($urandom), W'($urandom), 1'($urandom));
    set_op(2, W'($urandom), W'($urandom), 1'($urandom));
    v = onehot(0) | onehot(2);
    bus.req_valid = v;
    for (int t = 0; t < 2; t++) begin
      eg = pick(v, model_ptr);
      wait_ready(vec);
      checks++; if (vec !== onehot(eg)) begin errors++; $display("FAIL rm_order_%0d: got %b want %b", t, vec, onehot(eg)); end
      get_op(eg, a, b, ci);
      exp_r = ref_add(a, b, ci);
      wait_rsp(s, c, id);
      v = v & ~onehot(eg);
      bus.req_valid = v;
      checks++; if (s !== exp_r[W-1:0] || c !== exp_r[W] || id !== IDW'(eg)) begin
        errors++; $display("FAIL rm_rsp_%0d: got s=%h c=%b id=%0d want s=%h c=%b id=%0d", t, s, c, id, exp_r[W-1:0], exp_r[W], eg); end
      model_ptr = (eg + 1) % NREQ; model_count = model_count + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_counter_wrap;
    logic [NREQ-1:0] vec;
    logic [W:0]      exp_r;
    logic [W-1:0]    s, a, b;
    logic            c, ci;
    logic [IDW-1:0]  id;
    int rid;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rid = $urandom_range(0, NREQ-1);
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      set_op(rid, a, b, ci);
      exp_r = ref_add(a, b, ci);
      bus.req_valid = onehot(rid);
      wait_ready(vec);
      wait_rsp(s, c, id);
      bus.req_valid = '0;
      checks++; if (vec !== onehot(rid) || s !== exp_r[W-1:0] || c !== exp_r[W] || id !== IDW'(rid)) begin
        errors++; $display("FAIL wrap_op_%0d: got g=%b s=%h c=%b id=%0d want g=%b s=%h c=%b id=%0d", i, vec, s, c, id, onehot(rid), exp_r[W-1:0], exp_r[W], rid); end
      model_count = model_count + 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (op_count !== model_count || op_count !== CNTW'(1)) begin
      errors++; $display("FAIL wrap_count: got %0d want 1", op_count); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
